// File: rtl/dsp_pkg.sv
// dsp_pkg: shared constants for the DSP round/saturate post-processing path.
//   P_WIDTH_DEF     - default signed width of the incoming multiplier/MACC result
//   OUT_WIDTH_DEF   - default signed output width (matches the DSP A/B operand width)
//   SHIFT_WIDTH_DEF - default width of the right-shift amount
//   SAT_CNT_WIDTH   - width of the saturation event counter
//   SAT_MAX/SAT_MIN - clamp limits for the default output width
package dsp_pkg;

  localparam int unsigned P_WIDTH_DEF     = 40;
  localparam int unsigned OUT_WIDTH_DEF   = 18;
  localparam int unsigned SHIFT_WIDTH_DEF = 6;
  localparam int unsigned SAT_CNT_WIDTH   = 16;

  // Largest value representable in a w-bit two's complement number.
  function automatic longint sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement number.
  function automatic longint sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(OUT_WIDTH_DEF);
  localparam longint SAT_MIN = sat_min(OUT_WIDTH_DEF);

endpackage : dsp_pkg

// File: rtl/dsp_pipe_stage.sv
// dsp_pipe_stage: single-entry valid/ready register slice.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake; in_ready is combinational
//   in_data             - payload captured on an accepted beat
//   out_valid/out_ready - downstream handshake; out_valid is the stage's full flag
//   out_data            - registered payload, held while out_valid && !out_ready
// The stage loads whenever it is empty or its current content leaves this cycle,
// so a chain of these sustains one beat per clock without a bubble.
module dsp_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Ready when empty, or when the held beat is consumed in this same cycle.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: refill on load slots, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // State register; reset empties the slot and zeroes the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule : dsp_pipe_stage

// File: rtl/dsp_round_sat.sv
// dsp_round_sat: rounds, right-shifts and saturates a signed DSP result down to
// the operand width, as a two-stage valid/ready pipeline.
//   CLK, ARST          - clock, asynchronous active-high reset (released synchronously
//                        by the integrating top level)
//   P_VALID/P_READY, P - input beat: signed P_WIDTH-bit result
//   SHIFT              - right-shift amount sampled with P; values above P_WIDTH-1
//                        behave as P_WIDTH-1
//   Y_VALID/Y_READY, Y - output beat: signed OUT_WIDTH-bit rounded/clamped result
//   SAT                - the current Y beat was clamped
//   SAT_STICKY         - a clamped beat has transferred since reset / SAT_CLR
//   SAT_CLR            - synchronous clear of SAT_STICKY and SAT_COUNT
//   SAT_COUNT          - number of clamped beats transferred, saturating at all-ones
// Stage 1 holds the rounded, shifted value at P_WIDTH+1 bits; stage 2 holds the
// clamped output and its SAT flag.
module dsp_round_sat
  import dsp_pkg::*;
#(
  parameter int unsigned P_WIDTH     = P_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic                     CLK,
  input  logic                     ARST,
  input  logic                     P_VALID,
  output logic                     P_READY,
  input  logic [P_WIDTH-1:0]       P,
  input  logic [SHIFT_WIDTH-1:0]   SHIFT,
  output logic                     Y_VALID,
  input  logic                     Y_READY,
  output logic [OUT_WIDTH-1:0]     Y,
  output logic                     SAT,
  output logic                     SAT_STICKY,
  input  logic                     SAT_CLR,
  output logic [SAT_CNT_WIDTH-1:0] SAT_COUNT
);

  // One extra bit so the rounding increment can never overflow.
  localparam int unsigned R_WIDTH  = P_WIDTH + 1;
  localparam int unsigned S2_WIDTH = OUT_WIDTH + 1;
  localparam int unsigned SH_MAX   = P_WIDTH - 1;

  localparam logic signed [R_WIDTH-1:0] R_MAX = R_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [R_WIDTH-1:0] R_MIN = R_WIDTH'(sat_min(OUT_WIDTH));

  localparam logic [SAT_CNT_WIDTH-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------- stage 1
  int unsigned               sh_amt;
  logic signed [R_WIDTH-1:0] p_ext;
  logic signed [R_WIDTH-1:0] rnd;
  logic signed [R_WIDTH-1:0] r_c;
  logic signed [R_WIDTH-1:0] r_q;
  logic                      v1;
  logic                      s2_ready;

  // Round half up: add half an output LSB, then arithmetic shift.
  always_comb begin
    sh_amt = 32'(SHIFT);
    if (sh_amt > SH_MAX) begin
      sh_amt = SH_MAX;
    end
    p_ext = R_WIDTH'(signed'(P));
    rnd   = '0;
    if (sh_amt != 0) begin
      rnd = R_WIDTH'(1) << (sh_amt - 1);
    end
    r_c = (p_ext + rnd) >>> sh_amt;
  end

  dsp_pipe_stage #(
    .WIDTH (R_WIDTH)
  ) u_stage1 (
    .clk       (CLK),
    .rst       (ARST),
    .in_valid  (P_VALID),
    .in_ready  (P_READY),
    .in_data   (r_c),
    .out_valid (v1),
    .out_ready (s2_ready),
    .out_data  (r_q)
  );

  // ---------------------------------------------------------------- stage 2
  logic [OUT_WIDTH-1:0] y_c;
  logic                 sat_c;
  logic [S2_WIDTH-1:0]  s2_q;

  // Clamp to the signed output range and flag any clamping.
  always_comb begin
    y_c   = OUT_WIDTH'(r_q);
    sat_c = 1'b0;
    if (r_q > R_MAX) begin
      y_c   = OUT_WIDTH'(R_MAX);
      sat_c = 1'b1;
    end else if (r_q < R_MIN) begin
      y_c   = OUT_WIDTH'(R_MIN);
      sat_c = 1'b1;
    end
  end

  dsp_pipe_stage #(
    .WIDTH (S2_WIDTH)
  ) u_stage2 (
    .clk       (CLK),
    .rst       (ARST),
    .in_valid  (v1),
    .in_ready  (s2_ready),
    .in_data   ({sat_c, y_c}),
    .out_valid (Y_VALID),
    .out_ready (Y_READY),
    .out_data  (s2_q)
  );

  assign {SAT, Y} = s2_q;

  // ------------------------------------------------------ saturation status
  logic                     sat_xfer;
  logic                     sat_sticky_q;
  logic                     sat_sticky_d;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_d;

  assign sat_xfer = Y_VALID && Y_READY && SAT;

  // A clear coinciding with a clamped transfer still records that transfer.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    sat_cnt_d    = sat_cnt_q;
    if (SAT_CLR) begin
      sat_sticky_d = sat_xfer;
      sat_cnt_d    = sat_xfer ? SAT_CNT_WIDTH'(1) : '0;
    end else if (sat_xfer) begin
      sat_sticky_d = 1'b1;
      if (sat_cnt_q != CNT_MAX) begin
        sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
      end
    end
  end

  // Status registers.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      sat_sticky_q <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      sat_sticky_q <= sat_sticky_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign SAT_STICKY = sat_sticky_q;
  assign SAT_COUNT  = sat_cnt_q;

endmodule : dsp_round_sat

// File: tb/tb_dsp_round_sat.sv
// tb_dsp_round_sat: self-checking bench for dsp_round_sat with directed scenarios
// and randomized traffic scored against an integer reference model.
module tb_dsp_round_sat;

  localparam int unsigned P_W = 40;
  localparam int unsigned O_W = 18;
  localparam int unsigned S_W = 6;

  logic           CLK = 1'b0;
  logic           ARST;
  logic           P_VALID;
  logic           P_READY;
  logic [P_W-1:0] P;
  logic [S_W-1:0] SHIFT;
  logic           Y_VALID;
  logic           Y_READY;
  logic [O_W-1:0] Y;
  logic           SAT;
  logic           SAT_STICKY;
  logic           SAT_CLR;
  logic [15:0]    SAT_COUNT;

  int n_cmp = 0;
  int n_err = 0;

  logic [O_W:0] obs_q[$];
  longint       stim_p[$];
  int           stim_sh[$];
  bit           last_acc;

  always #5 CLK = ~CLK;

  dsp_round_sat #(
    .P_WIDTH     (P_W),
    .OUT_WIDTH   (O_W),
    .SHIFT_WIDTH (S_W)
  ) dut (
    .CLK        (CLK),
    .ARST       (ARST),
    .P_VALID    (P_VALID),
    .P_READY    (P_READY),
    .P          (P),
    .SHIFT      (SHIFT),
    .Y_VALID    (Y_VALID),
    .Y_READY    (Y_READY),
    .Y          (Y),
    .SAT        (SAT),
    .SAT_STICKY (SAT_STICKY),
    .SAT_CLR    (SAT_CLR),
    .SAT_COUNT  (SAT_COUNT)
  );

  // Reference: floor((p + half) / 2^s) clamped to the output range; returns {sat, y}.
  function automatic logic [O_W:0] ref_model(input longint p, input int sh);
    longint r;
    longint hi;
    longint lo;
    int     s;
    bit     sat;
    s  = (sh > int'(P_W) - 1) ? int'(P_W) - 1 : sh;
    r  = p + ((s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0);
    r  = r >>> s;
    hi = (64'sd1 <<< (O_W - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (O_W - 1));
    sat = 1'b0;
    if (r > hi) begin
      r = hi; sat = 1'b1;
    end else if (r < lo) begin
      r = lo; sat = 1'b1;
    end
    return {sat, O_W'(r)};
  endfunction

  function automatic logic [O_W:0] pack_exp(input bit sat, input longint y);
    return {sat, O_W'(y)};
  endfunction

  // One clock: sample handshakes before the edge, end on the next falling edge.
  task automatic step();
    #1;
    last_acc = P_VALID && P_READY;
    if (Y_VALID && Y_READY) obs_q.push_back({SAT, Y});
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Feed stim queues until empty and n_expect outputs were collected (bounded).
  task automatic drive_all(input int ready_pct, input int max_cycles, input int n_expect);
    int cyc;
    cyc = 0;
    while ((stim_p.size() > 0 || obs_q.size() < n_expect) && cyc < max_cycles) begin
      P_VALID = (stim_p.size() > 0) && (ready_pct >= 100 || $urandom_range(3) != 0);
      if (stim_p.size() > 0) begin
        P     = P_W'(stim_p[0]);
        SHIFT = S_W'(stim_sh[0]);
      end
      Y_READY = (ready_pct >= 100) || (int'($urandom_range(99)) < ready_pct);
      step();
      if (last_acc) begin
        void'(stim_p.pop_front());
        void'(stim_sh.pop_front());
      end
      cyc++;
    end
    P_VALID = 1'b0;
    Y_READY = 1'b1;
  endtask

  task automatic test_reset();
    ARST = 1'b1; P_VALID = 1'b0; P = '0; SHIFT = '0; Y_READY = 1'b1; SAT_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (Y_VALID !== 1'b0) begin n_err++; $display("FAIL reset_y_valid got %b want 0", Y_VALID); end
    n_cmp++; if (Y !== '0) begin n_err++; $display("FAIL reset_y got %h want 0", Y); end
    n_cmp++; if (SAT !== 1'b0) begin n_err++; $display("FAIL reset_sat got %b want 0", SAT); end
    n_cmp++; if (SAT_STICKY !== 1'b0) begin n_err++; $display("FAIL reset_sticky got %b want 0", SAT_STICKY); end
    n_cmp++; if (SAT_COUNT !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", SAT_COUNT); end
    n_cmp++; if (P_READY !== 1'b1) begin n_err++; $display("FAIL reset_p_ready got %b want 1", P_READY); end
    @(negedge CLK);
    ARST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_latency();
    obs_q.delete();
    P = P_W'(100); SHIFT = '0; P_VALID = 1'b1; Y_READY = 1'b1;
    step();
    n_cmp++; if (last_acc !== 1'b1) begin n_err++; $display("FAIL latency_accept got %b want 1", last_acc); end
    P_VALID = 1'b0;
    n_cmp++; if (Y_VALID !== 1'b0) begin n_err++; $display("FAIL latency_early got %b want 0", Y_VALID); end
    step();
    n_cmp++; if (Y_VALID !== 1'b1) begin n_err++; $display("FAIL latency_valid got %b want 1", Y_VALID); end
    n_cmp++; if ({SAT, Y} !== pack_exp(1'b0, 100)) begin n_err++; $display("FAIL latency_data got %h want %h", {SAT, Y}, pack_exp(1'b0, 100)); end
    step();
    obs_q.delete();
  endtask

  task automatic test_rounding();
    logic [O_W:0] exp_v[3];
    obs_q.delete();
    stim_p = '{24, -24, 23}; stim_sh = '{4, 4, 4};
    exp_v[0] = pack_exp(1'b0, 2); exp_v[1] = pack_exp(1'b0, -1); exp_v[2] = pack_exp(1'b0, 1);
    drive_all(100, 30, 3);
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL round_count got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_v[i]) begin n_err++; $display("FAIL round_beat%0d got %h want %h", i, obs_q[i], exp_v[i]); end
    end
  endtask

  task automatic test_saturate();
    obs_q.delete();
    stim_p = '{64'sd1 <<< 20, -(64'sd1 <<< 20)}; stim_sh = '{0, 0};
    drive_all(100, 30, 2);
    n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL sat_count_beats got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_cmp++; if (obs_q[0] !== pack_exp(1'b1, 131071)) begin n_err++; $display("FAIL sat_pos got %h want %h", obs_q[0], pack_exp(1'b1, 131071)); end
      n_cmp++; if (obs_q[1] !== pack_exp(1'b1, -131072)) begin n_err++; $display("FAIL sat_neg got %h want %h", obs_q[1], pack_exp(1'b1, -131072)); end
    end
    n_cmp++; if (SAT_STICKY !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %b want 1", SAT_STICKY); end
    n_cmp++; if (SAT_COUNT !== 16'd2) begin n_err++; $display("FAIL sat_counter got %0d want 2", SAT_COUNT); end
  endtask

  task automatic test_shift_clamp();
    logic [O_W:0] exp_v[5];
    longint pmax;
    longint pmin;
    pmax = (64'sd1 <<< 39) - 64'sd1;
    pmin = -(64'sd1 <<< 39);
    obs_q.delete();
    stim_p  = '{pmax, pmin, pmax, pmax, pmin};
    stim_sh = '{1, 63, 40, 39, 0};
    exp_v[0] = pack_exp(1'b1, 131071);
    exp_v[1] = pack_exp(1'b0, -1);
    exp_v[2] = pack_exp(1'b0, 1);
    exp_v[3] = pack_exp(1'b0, 1);
    exp_v[4] = pack_exp(1'b1, -131072);
    drive_all(100, 40, 5);
    n_cmp++; if (obs_q.size() !== 5) begin n_err++; $display("FAIL clamp_count got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_v[i]) begin n_err++; $display("FAIL clamp_beat%0d got %h want %h", i, obs_q[i], exp_v[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [O_W:0] exp_v[4];
    logic [O_W:0] held;
    bit           have_held;
    int           acc;
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      stim_p.push_back(64'($urandom_range(200000)) - 64'sd100000);
      stim_sh.push_back(int'($urandom_range(3)));
      exp_v[i] = ref_model(stim_p[i], stim_sh[i]);
    end
    acc = 0; have_held = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      P_VALID = stim_p.size() > 0;
      if (stim_p.size() > 0) begin P = P_W'(stim_p[0]); SHIFT = S_W'(stim_sh[0]); end
      Y_READY = 1'b0;
      step();
      if (last_acc) begin acc++; void'(stim_p.pop_front()); void'(stim_sh.pop_front()); end
      if (Y_VALID) begin
        if (!have_held) begin
          held = {SAT, Y}; have_held = 1'b1;
        end else begin
          n_cmp++; if ({SAT, Y} !== held) begin n_err++; $display("FAIL bp_stable got %h want %h", {SAT, Y}, held); end
        end
      end
    end
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL bp_accepts got %0d want 2", acc); end
    n_cmp++; if (P_READY !== 1'b0) begin n_err++; $display("FAIL bp_p_ready got %b want 0", P_READY); end
    n_cmp++; if (held !== exp_v[0]) begin n_err++; $display("FAIL bp_head got %h want %h", held, exp_v[0]); end
    drive_all(100, 40, 4);
    n_cmp++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL bp_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_v[i]) begin n_err++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_v[i]); end
    end
  endtask

  // Hold one beat at the output, then release it together with a SAT_CLR pulse.
  task automatic clr_with_beat(input longint p, input string tag, input bit exp_sticky, input logic [15:0] exp_cnt);
    int cyc;
    P = P_W'(p); SHIFT = '0; P_VALID = 1'b1; Y_READY = 1'b0; cyc = 0;
    do begin
      step();
      if (last_acc) P_VALID = 1'b0;
      cyc++;
    end while (!Y_VALID && cyc < 10);
    P_VALID = 1'b0;
    n_cmp++; if (Y_VALID !== 1'b1) begin n_err++; $display("FAIL %s_wait got %b want 1", tag, Y_VALID); end
    SAT_CLR = 1'b1; Y_READY = 1'b1;
    step();
    SAT_CLR = 1'b0;
    n_cmp++; if (SAT_STICKY !== exp_sticky) begin n_err++; $display("FAIL %s_sticky got %b want %b", tag, SAT_STICKY, exp_sticky); end
    n_cmp++; if (SAT_COUNT !== exp_cnt) begin n_err++; $display("FAIL %s_count got %0d want %0d", tag, SAT_COUNT, exp_cnt); end
  endtask

  task automatic test_sat_clr();
    SAT_CLR = 1'b1;
    step();
    SAT_CLR = 1'b0;
    n_cmp++; if (SAT_COUNT !== 16'd0) begin n_err++; $display("FAIL clr_count got %0d want 0", SAT_COUNT); end
    n_cmp++; if (SAT_STICKY !== 1'b0) begin n_err++; $display("FAIL clr_sticky got %b want 0", SAT_STICKY); end
    obs_q.delete();
    for (int i = 0; i < 5; i++) begin
      stim_p.push_back((i % 2 == 0) ? (64'sd1 <<< 30) : -(64'sd1 <<< 30));
      stim_sh.push_back(int'($urandom_range(5)));
    end
    drive_all(100, 40, 5);
    n_cmp++; if (SAT_COUNT !== 16'd5) begin n_err++; $display("FAIL clr_pre_count got %0d want 5", SAT_COUNT); end
    clr_with_beat(-(64'sd1 <<< 30), "clr_sat", 1'b1, 16'd1);
    clr_with_beat(64'sd5, "clr_nosat", 1'b0, 16'd0);
  endtask

  task automatic test_random();
    logic [O_W:0] exp_q[$];
    longint p;
    int     sh;
    int     nsat;
    SAT_CLR = 1'b1;
    step();
    SAT_CLR = 1'b0;
    obs_q.delete();
    nsat = 0;
    for (int i = 0; i < 300; i++) begin
      sh = int'($urandom_range(63));
      case ($urandom_range(3))
        0: p = 64'($urandom_range(8388608)) - 64'sd4194304;
        1: begin p = longint'({$urandom, $urandom}); p = (p <<< 24) >>> 24; end
        2: p = ($urandom_range(1) == 0) ? ((64'sd1 <<< 39) - 64'($urandom_range(3)) - 64'sd1)
                                        : (64'($urandom_range(3)) - (64'sd1 <<< 39));
        default: p = 64'($urandom_range(2000)) - 64'sd1000;
      endcase
      stim_p.push_back(p);
      stim_sh.push_back(sh);
      exp_q.push_back(ref_model(p, sh));
      if (exp_q[i][O_W]) nsat++;
    end
    drive_all(70, 3000, 300);
    n_cmp++; if (obs_q.size() !== 300) begin n_err++; $display("FAIL rand_count got %0d want 300", obs_q.size()); end
    for (int i = 0; i < 300 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (SAT_COUNT !== 16'(nsat)) begin n_err++; $display("FAIL rand_sat_count got %0d want %0d", SAT_COUNT, nsat); end
    n_cmp++; if (SAT_STICKY !== (nsat > 0)) begin n_err++; $display("FAIL rand_sticky got %b want %b", SAT_STICKY, nsat > 0); end
  endtask

  task automatic test_reset_inflight();
    int acc;
    obs_q.delete();
    stim_p = '{64'sd1 <<< 25}; stim_sh = '{0};
    drive_all(100, 20, 1);
    stim_p.delete(); stim_sh.delete();
    n_cmp++; if (SAT_COUNT === 16'd0) begin n_err++; $display("FAIL rst_pre_count got %0d want nonzero", SAT_COUNT); end
    acc = 0;
    P = P_W'(64'sd1 <<< 25); SHIFT = '0; P_VALID = 1'b1; Y_READY = 1'b0;
    repeat (2) begin
      step();
      if (last_acc) acc++;
    end
    P_VALID = 1'b0;
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL rst_inflight got %0d want 2", acc); end
    ARST = 1'b1;
    #1;
    n_cmp++; if (Y_VALID !== 1'b0) begin n_err++; $display("FAIL rst_y_valid got %b want 0", Y_VALID); end
    n_cmp++; if (SAT_COUNT !== 16'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", SAT_COUNT); end
    n_cmp++; if (P_READY !== 1'b1) begin n_err++; $display("FAIL rst_p_ready got %b want 1", P_READY); end
    @(negedge CLK);
    ARST = 1'b0; Y_READY = 1'b1;
    obs_q.delete();
    repeat (6) step();
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL rst_ghost got %0d want 0", obs_q.size()); end
    n_cmp++; if (Y_VALID !== 1'b0) begin n_err++; $display("FAIL rst_after got %b want 0", Y_VALID); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturate();
    test_shift_clamp();
    test_backpressure();
    test_sat_clr();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dsp_round_sat
